// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - shared widths, state encoding and helpers for the song sequencer
package song_sequencer_pkg;

   localparam int SONG_BITS     = 2;
   localparam int SONG_CNT_BITS = 4;
   localparam int OCTAVE_BITS   = 3;
   localparam int NOTE_BITS     = 4;
   localparam int LENGTH_BITS   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_WAIT_ACK,
      ST_PLAY,
      ST_GAP,
      ST_PAUSED,
      ST_DONE
   } seq_state_e;

   // Counter width able to hold n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// rtl/seq_gap_timer.sv - loadable down-counter with expiry flag, shared by gap and start timeout
module seq_gap_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps through the song ROM and hands each note to the sound engine
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int GAP_CYCLES = 200_000,
   parameter int START_TMO  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     play,
   input  logic                     pause,
   input  logic                     stop,
   input  logic                     loop,
   input  logic [SONG_BITS-1:0]     song,
   output logic [SONG_BITS-1:0]     rom_song,
   output logic [SONG_CNT_BITS-1:0] rom_idx,
   input  logic [SONG_CNT_BITS-1:0] rom_track,
   input  logic [OCTAVE_BITS-1:0]   rom_octave,
   input  logic [NOTE_BITS-1:0]     rom_note,
   input  logic [LENGTH_BITS-1:0]   rom_length,
   output logic                     snd_start,
   output logic [OCTAVE_BITS-1:0]   snd_octave,
   output logic [NOTE_BITS-1:0]     snd_note,
   output logic [LENGTH_BITS-1:0]   snd_length,
   input  logic                     snd_over,
   output logic                     busy,
   output logic                     done
);

   localparam int TMR_MAX = (GAP_CYCLES > START_TMO) ? GAP_CYCLES : START_TMO;
   localparam int TMR_W   = cnt_width(TMR_MAX);
   // The timer expires on the last cycle of the state, hence the minus one.
   localparam int GAP_LD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int TMO_LD  = (START_TMO > 0) ? START_TMO - 1 : 0;
   localparam logic [TMR_W-1:0] GAP_LD_V = TMR_W'(GAP_LD);
   localparam logic [TMR_W-1:0] TMO_LD_V = TMR_W'(TMO_LD);

   seq_state_e state_q, state_d;
   logic [SONG_BITS-1:0]     rom_song_q, rom_song_d;
   logic [SONG_CNT_BITS-1:0] rom_idx_q, rom_idx_d;
   logic [OCTAVE_BITS-1:0]   snd_octave_q, snd_octave_d;
   logic [NOTE_BITS-1:0]     snd_note_q, snd_note_d;
   logic [LENGTH_BITS-1:0]   snd_length_q, snd_length_d;
   logic                     done_q, done_d;
   logic                     tmr_load, tmr_expired, boundary;
   logic [TMR_W-1:0]         tmr_val;

   seq_gap_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rom_song_q   <= '0;
         rom_idx_q    <= '0;
         snd_octave_q <= '0;
         snd_note_q   <= '0;
         snd_length_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rom_song_q   <= rom_song_d;
         rom_idx_q    <= rom_idx_d;
         snd_octave_q <= snd_octave_d;
         snd_note_q   <= snd_note_d;
         snd_length_q <= snd_length_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rom_song_d   = rom_song_q;
      rom_idx_d    = rom_idx_q;
      snd_octave_d = snd_octave_q;
      snd_note_d   = snd_note_q;
      snd_length_d = snd_length_q;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = GAP_LD_V;
      boundary     = 1'b0;

      if (!en || stop) begin
         state_d   = ST_IDLE;
         rom_idx_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (play) begin
                  rom_song_d = song;
                  rom_idx_d  = '0;
                  state_d    = ST_FETCH;
               end
            end
            ST_FETCH: begin
               snd_octave_d = rom_octave;
               snd_note_d   = rom_note;
               snd_length_d = rom_length;
               state_d      = ST_START;
            end
            ST_START: begin
               tmr_load = 1'b1;
               tmr_val  = TMO_LD_V;
               state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (!snd_over) begin
                  state_d = ST_PLAY;
               end else if (tmr_expired) begin
                  // Engine never acknowledged (zero-length note): count it as played.
                  tmr_load = 1'b1;
                  state_d  = ST_GAP;
               end
            end
            ST_PLAY: begin
               if (snd_over) begin
                  tmr_load = 1'b1;
                  state_d  = ST_GAP;
               end
            end
            ST_GAP: begin
               if (tmr_expired) begin
                  if (pause) state_d = ST_PAUSED;
                  else       boundary = 1'b1;
               end
            end
            ST_PAUSED: begin
               if (play) boundary = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase

         if (boundary) begin
            if (rom_idx_q < rom_track) begin
               rom_idx_d = rom_idx_q + SONG_CNT_BITS'(1);
               state_d   = ST_FETCH;
            end else if (loop) begin
               rom_idx_d = '0;
               state_d   = ST_FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
      end
   end

   assign rom_song   = rom_song_q;
   assign rom_idx    = rom_idx_q;
   assign snd_octave = snd_octave_q;
   assign snd_note   = snd_note_q;
   assign snd_length = snd_length_q;
   assign snd_start  = (state_q == ST_START) && en && !stop;
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer with ROM and engine models
module tb_song_sequencer;
   import song_sequencer_pkg::*;

   localparam int GAP      = 4;
   localparam int TMO      = 4;
   localparam int NOTE_LEN = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1, play = 1'b0, pause = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [SONG_BITS-1:0]     song = '0;
   logic [SONG_BITS-1:0]     rom_song;
   logic [SONG_CNT_BITS-1:0] rom_idx, rom_track;
   logic [OCTAVE_BITS-1:0]   rom_octave, snd_octave;
   logic [NOTE_BITS-1:0]     rom_note, snd_note;
   logic [LENGTH_BITS-1:0]   rom_length, snd_length;
   logic snd_start, snd_over, busy, done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit zero_len = 1'b0;
   int eng_cnt  = 0;

   song_sequencer #(.GAP_CYCLES(GAP), .START_TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .play(play), .pause(pause), .stop(stop),
      .loop(loop), .song(song), .rom_song(rom_song), .rom_idx(rom_idx),
      .rom_track(rom_track), .rom_octave(rom_octave), .rom_note(rom_note),
      .rom_length(rom_length), .snd_start(snd_start), .snd_octave(snd_octave),
      .snd_note(snd_note), .snd_length(snd_length), .snd_over(snd_over),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Song ROM contents: last-note index per song and a note-field pattern.
   function automatic int trk(input int s);
      case (s)
         0: return 0;
         1: return 2;
         2: return 1;
         default: return 3;
      endcase
   endfunction
   function automatic int f_oct(input int s, input int i);  return (s * 2 + i + 1) % 8;  endfunction
   function automatic int f_note(input int s, input int i); return (s * 5 + i * 3 + 2) % 16; endfunction
   function automatic int f_len(input int s, input int i);  return (i + s + 3) % 16; endfunction

   always_comb begin
      rom_track  = SONG_CNT_BITS'(trk(int'(rom_song)));
      rom_octave = OCTAVE_BITS'(f_oct(int'(rom_song), int'(rom_idx)));
      rom_note   = NOTE_BITS'(f_note(int'(rom_song), int'(rom_idx)));
      rom_length = LENGTH_BITS'(f_len(int'(rom_song), int'(rom_idx)));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Sound engine: drops snd_over for NOTE_LEN cycles per start, or never in zero-length mode.
   initial begin
      snd_over = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (snd_start === 1'b1 && !zero_len) begin
            eng_cnt  = NOTE_LEN;
            snd_over = 1'b0;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) snd_over = 1'b1;
         end
      end
   end

   // Reference model: predicts when notes start, which note, when done pulses and busy.
   int m_song, m_cur_idx, m_start_cyc;
   int m_exp_start, m_exp_done, m_go_busy_at, m_go_idle_at, m_decide_at, m_paused_at;
   bit m_busy, m_note_active, m_acked;
   int obs_sc[$], obs_si[$], obs_dc[$];

   task automatic model_reset();
      m_song = 0; m_cur_idx = 0; m_start_cyc = 0;
      m_exp_start = -1; m_exp_done = -1; m_go_busy_at = -1; m_go_idle_at = -1;
      m_decide_at = -1; m_paused_at = -1;
      m_busy = 1'b0; m_note_active = 1'b0; m_acked = 1'b0;
   endtask

   task automatic advance(input int d);
      if (m_cur_idx < trk(m_song)) begin
         m_cur_idx++;
         m_exp_start = d + 2;
      end else if (loop) begin
         m_cur_idx   = 0;
         m_exp_start = d + 2;
      end else begin
         m_exp_done = d + 1;
      end
   endtask

   task automatic model_step();
      int  c;
      bit  exp_st;
      c = cyc;
      if (c == m_go_busy_at) m_busy = 1'b1;
      if (c == m_exp_done)   m_busy = 1'b0;
      if (c == m_go_idle_at) m_busy = 1'b0;
      exp_st = (c == m_exp_start) && en && !stop;

      chk("busy", busy, m_busy);
      chk("snd_start", snd_start, exp_st);
      chk("done", done, c == m_exp_done);
      if (c == m_go_idle_at) chk("stop_idx", rom_idx, 0);
      if (snd_start === 1'b1) begin
         obs_sc.push_back(c);
         obs_si.push_back(int'(rom_idx));
      end
      if (done === 1'b1) obs_dc.push_back(c);

      if (exp_st) begin
         chk("start_idx", rom_idx, m_cur_idx);
         chk("start_song", rom_song, m_song);
         chk("snd_octave", snd_octave, f_oct(m_song, m_cur_idx));
         chk("snd_note", snd_note, f_note(m_song, m_cur_idx));
         chk("snd_length", snd_length, f_len(m_song, m_cur_idx));
         m_note_active = 1'b1;
         m_start_cyc   = c;
         m_acked       = 1'b0;
      end

      if (m_note_active && c > m_start_cyc) begin
         if (!m_acked) begin
            if (!snd_over) m_acked = 1'b1;
            else if (c - m_start_cyc >= TMO) begin
               m_note_active = 1'b0;
               m_decide_at   = c + ((GAP > 0) ? GAP : 1);
            end
         end else if (snd_over) begin
            m_note_active = 1'b0;
            m_decide_at   = c + ((GAP > 0) ? GAP : 1);
         end
      end

      if (c == m_decide_at) begin
         m_decide_at = -1;
         if (pause) m_paused_at = c + 1;
         else       advance(c);
      end

      if (!en || stop) begin
         m_exp_start = -1; m_exp_done = -1; m_decide_at = -1; m_paused_at = -1;
         m_go_busy_at = -1; m_note_active = 1'b0;
         m_go_idle_at = c + 1;
      end else if (play) begin
         if (m_paused_at >= 0 && c >= m_paused_at) begin
            m_paused_at = -1;
            advance(c);
         end else if (!m_busy && m_go_busy_at <= c) begin
            m_song       = int'(song);
            m_cur_idx    = 0;
            m_exp_start  = c + 2;
            m_go_busy_at = c + 1;
            m_exp_done   = -1;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_play(output int pc);
      tick(1);
      play = 1'b1;
      pc   = cyc;
      tick(1);
      play = 1'b0;
   endtask

   task automatic clear_obs();
      obs_sc.delete();
      obs_si.delete();
      obs_dc.delete();
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_snd_start"}, snd_start, 0);
      chk({tag, "_rom_idx"}, rom_idx, 0);
      chk({tag, "_rom_song"}, rom_song, 0);
      chk({tag, "_snd_octave"}, snd_octave, 0);
      chk({tag, "_snd_note"}, snd_note, 0);
      chk({tag, "_snd_length"}, snd_length, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p, q;
      tick(2);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      tick(3);

      // 1: three-note song, no loop
      clear_obs();
      song = 2'd1; loop = 1'b0;
      do_play(p);
      tick(60);
      chk("t1_starts", obs_sc.size(), 3);
      chk("t1_latency", qget(obs_sc, 0) - p, 2);
      chk("t1_interval", qget(obs_sc, 1) - qget(obs_sc, 0), 16);
      for (int i = 0; i < 3; i++) chk("t1_idx", qget(obs_si, i), i);
      chk("t1_done_n", obs_dc.size(), 1);
      chk("t1_done_lat", qget(obs_dc, 0) - qget(obs_sc, 2), 15);
      chk("t1_busy_end", busy, 0);

      // 2: looping song wraps to index 0
      clear_obs();
      loop = 1'b1;
      do_play(p);
      tick(56);
      chk("t2_starts", obs_sc.size(), 4);
      chk("t2_idx3", qget(obs_si, 3), 0);
      chk("t2_no_done", obs_dc.size(), 0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      loop = 1'b0;
      chk("t2_stop_busy", busy, 0);
      tick(15);

      // 3: pause mid-note, resume with play
      clear_obs();
      do_play(p);
      tick(6);
      pause = 1'b1;
      tick(15);
      chk("t3_paused_starts", obs_sc.size(), 1);
      chk("t3_paused_busy", busy, 1);
      pause = 1'b0;
      do_play(q);
      tick(40);
      chk("t3_starts", obs_sc.size(), 3);
      chk("t3_resume_lat", qget(obs_sc, 1) - q, 2);
      chk("t3_resume_idx", qget(obs_si, 1), 1);
      chk("t3_done_n", obs_dc.size(), 1);

      // 4a: stop during PLAY at idx 1
      clear_obs();
      do_play(p);
      tick(21);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("t4a_busy", busy, 0);
      chk("t4a_idx", rom_idx, 0);
      tick(20);
      chk("t4a_starts", obs_sc.size(), 2);
      chk("t4a_no_done", obs_dc.size(), 0);

      // 4b: en low during PLAY at idx 1
      clear_obs();
      do_play(p);
      tick(21);
      en = 1'b0;
      tick(1);
      chk("t4b_busy", busy, 0);
      chk("t4b_idx", rom_idx, 0);
      tick(1);
      en = 1'b1;
      tick(20);
      chk("t4b_starts", obs_sc.size(), 2);
      chk("t4b_no_done", obs_dc.size(), 0);

      // 5: engine never acknowledges
      clear_obs();
      zero_len = 1'b1;
      song = 2'd2;
      do_play(p);
      tick(30);
      chk("t5_starts", obs_sc.size(), 2);
      chk("t5_interval", qget(obs_sc, 1) - qget(obs_sc, 0), 10);
      chk("t5_idx1", qget(obs_si, 1), 1);
      chk("t5_done_n", obs_dc.size(), 1);
      chk("t5_done_lat", qget(obs_dc, 0) - qget(obs_sc, 1), 9);
      zero_len = 1'b0;
      tick(5);

      // 6: song change while busy, async reset mid-GAP
      clear_obs();
      song = 2'd1;
      do_play(p);
      tick(4);
      song = 2'd3;
      tick(9);
      chk("t6_song_held", rom_song, 1);
      chk("t6_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("t6_async");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(3);
      chk("t6_song_after_rst", rom_song, 0);
      chk("t6_busy_after_rst", busy, 0);
      clear_obs();
      do_play(p);
      tick(70);
      chk("t6_starts", obs_sc.size(), 4);
      chk("t6_idx3", qget(obs_si, 3), 3);
      chk("t6_done_n", obs_dc.size(), 1);
      chk("t6_song_new", rom_song, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
